// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: TX sequencer state encoding, the
//                TX data register bus address, and the default FIFO depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Launch sequencer states for the TX buffer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_state_t;

    // CPU bus address of the TX data register feeding the buffer
    localparam logic [31:0] C_UART_TXDATA_ADDR = 32'h4000_0018;

    // Default TX FIFO depth (entries)
    localparam int C_UART_TXBUF_DEPTH = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_status_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_status_sync
//  Description : Multi-flop synchronizer for a UART status level crossing
//                from the baud domain. Flops preset to 1 so that reset
//                reports the sender/receiver as idle.
//  Ports       : clk       - destination clock
//                rst_n     - asynchronous active-low reset
//                i_status  - asynchronous status level
//                o_status  - synchronized status level
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_status_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_status,
    output logic o_status
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_status};
        end
    end

    assign o_status = r_sync[SYNC_STAGES-1];

endmodule : uart_status_sync
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffer
//  Description : Byte FIFO and launch sequencer in front of the UART sender.
//                The CPU pushes bytes in the sysclk domain; the sequencer
//                hands them to the sender one at a time over the
//                tx_en / tx_status handshake.
//  Ports       : sysclk    - system clock (rising edge)
//                reset_    - asynchronous active-low reset
//                wr_en     - push request
//                wr_data   - byte to push
//                clr_ovf   - clear overflow flag (and statistics)
//                tx_status - sender idle flag, baud domain (1 = idle)
//                tx_en     - launch request to sender (level held)
//                tx_data   - byte presented to sender
//                full      - FIFO holds DEPTH entries
//                empty     - FIFO holds no entries
//                level     - current entry count
//                overflow  - sticky: a push was dropped
//                sent_cnt  - [UART_TXBUF_STATS_EN] bytes handed to sender
//                drop_cnt  - [UART_TXBUF_STATS_EN] dropped pushes, saturating
//  Options     : define UART_TXBUF_STATS_EN to add sent_cnt / drop_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH       = C_UART_TXBUF_DEPTH,
    parameter int AW          = $clog2(DEPTH),
    parameter int SYNC_STAGES = 2
) (
    input  logic          sysclk,
    input  logic          reset_,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    input  logic          tx_status,
    output logic          tx_en,
    output logic [7:0]    tx_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
`ifdef UART_TXBUF_STATS_EN
    ,
    output logic [15:0]   sent_cnt,
    output logic [7:0]    drop_cnt
`endif
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    tx_state_t     r_state;

    logic          w_st_s;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // ------------------------------------------------------------------
    // Sender status crossing into sysclk
    // ------------------------------------------------------------------
    uart_status_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_status_sync (
        .clk      (sysclk),
        .rst_n    (reset_),
        .i_status (tx_status),
        .o_status (w_st_s)
    );

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign full  = (r_level == (AW+1)'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

    // Pop depends only on registered state, so a byte written this cycle
    // cannot fall through; it is visible to the pop on the next edge.
    assign w_pop  = (r_state == IDLE) && !empty && w_st_s;
    // A pop frees a slot in the same edge, so a full FIFO still accepts.
    assign w_push = wr_en && (!full || w_pop);
    assign w_drop = wr_en && full && !w_pop;

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed; validity is tracked by r_level)
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, level and overflow
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge reset_) begin
        if (!reset_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (AW+1)'(1);
            end

            // A drop in the same cycle as a clear must stay visible
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Launch sequencer
    // tx_en is level-held through LAUNCH because the sender samples it on
    // its own baud edge; only the synchronized busy indication releases it.
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    tx_en <= 1'b0;
                    if (w_pop) begin
                        tx_data <= r_mem[r_rd_ptr];
                        tx_en   <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!w_st_s) begin
                        tx_en   <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    tx_en <= 1'b0;
                    if (w_st_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    tx_en   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXBUF_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: clear has priority over any increment
    // ------------------------------------------------------------------
    logic w_sent;
    assign w_sent = (r_state == LAUNCH) && !w_st_s;

    always_ff @(posedge sysclk or negedge reset_) begin
        if (!reset_) begin
            sent_cnt <= 16'h0000;
            drop_cnt <= 8'h00;
        end else if (clr_ovf) begin
            sent_cnt <= 16'h0000;
            drop_cnt <= 8'h00;
        end else begin
            if (w_sent) begin
                sent_cnt <= sent_cnt + 16'h0001;
            end
            if (w_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'h01;
            end
        end
    end
`endif

endmodule : uart_tx_buffer
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_buffer
//  Description : Directed self-checking bench for uart_tx_buffer. The bench
//                plays the UART sender by driving tx_status by hand.
//  Options     : define UART_TXBUF_STATS_EN to exercise sent_cnt / drop_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;

    localparam int C_DEPTH = 16;
    localparam int C_AW    = 4;
    localparam int C_BOUND = 64;

    logic            sysclk = 1'b0;
    logic            reset_;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            clr_ovf;
    logic            tx_status;
    logic            tx_en;
    logic [7:0]      tx_data;
    logic            full;
    logic            empty;
    logic [C_AW:0]   level;
    logic            overflow;
`ifdef UART_TXBUF_STATS_EN
    logic [15:0]     sent_cnt;
    logic [7:0]      drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sysclk = ~sysclk;

    uart_tx_buffer #(
        .DEPTH       (C_DEPTH),
        .AW          (C_AW),
        .SYNC_STAGES (2)
    ) u_dut (
        .sysclk    (sysclk),
        .reset_    (reset_),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_ovf   (clr_ovf),
        .tx_status (tx_status),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
`ifdef UART_TXBUF_STATS_EN
        ,
        .sent_cnt  (sent_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge sysclk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_txen(input logic val, input string tag);
        int i = 0;
        while (tx_en !== val && i < C_BOUND) begin
            @(negedge sysclk);
            i++;
        end
        if (tx_en !== val) check_eq({tag, " timeout"}, 32'(tx_en), 32'(val));
    endtask

    // One sender transaction: accept launch, go busy, return to idle
    task automatic send_one(input logic [7:0] exp);
        wait_txen(1'b1, "launch");
        check_eq("tx_data", 32'(tx_data), 32'(exp));
        tx_status = 1'b0;
        wait_txen(1'b0, "ack");
        tx_status = 1'b1;
    endtask

    initial begin
        logic [7:0] v;

        reset_    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        clr_ovf   = 1'b0;
        tx_status = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(negedge sysclk);
        check_eq("rst tx_en",    32'(tx_en),    32'd0);
        check_eq("rst tx_data",  32'(tx_data),  32'h00);
        check_eq("rst empty",    32'(empty),    32'd1);
        check_eq("rst full",     32'(full),     32'd0);
        check_eq("rst level",    32'(level),    32'd0);
        check_eq("rst overflow", 32'(overflow), 32'd0);
        reset_ = 1'b1;
        @(negedge sysclk);

        // ---------------- single byte ----------------
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge sysclk);              // after edge k
        wr_en = 1'b0;
        check_eq("single nofall tx_en", 32'(tx_en), 32'd0);
        check_eq("single level1",       32'(level), 32'd1);
        @(negedge sysclk);              // after edge k+1
        check_eq("single tx_en",   32'(tx_en),   32'd1);
        check_eq("single tx_data", 32'(tx_data), 32'hA5);
        check_eq("single empty",   32'(empty),   32'd1);
        tx_status = 1'b0;
        @(negedge sysclk);
        check_eq("single hold1", 32'(tx_en), 32'd1);
        @(negedge sysclk);
        check_eq("single hold2", 32'(tx_en), 32'd1);
        @(negedge sysclk);
        check_eq("single drop", 32'(tx_en), 32'd0);
        tx_status = 1'b1;
        repeat (4) @(negedge sysclk);
        check_eq("single idle empty", 32'(empty), 32'd1);
        check_eq("single idle tx_en", 32'(tx_en), 32'd0);

        // ---------------- burst into busy sender ----------------
        tx_status = 1'b0;
        repeat (4) @(negedge sysclk);
        for (int i = 1; i <= 16; i++) push(8'(i));
        check_eq("burst full",  32'(full),  32'd1);
        check_eq("burst level", 32'(level), 32'd16);
        check_eq("burst tx_en", 32'(tx_en), 32'd0);
        push(8'hFF);
        check_eq("ovf set",      32'(overflow), 32'd1);
        check_eq("ovf level",    32'(level),    32'd16);

        // drop and clear together: set wins
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        clr_ovf = 1'b1;
        @(negedge sysclk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check_eq("ovf set wins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        @(negedge sysclk);
        clr_ovf = 1'b0;
        check_eq("ovf cleared", 32'(overflow), 32'd0);

        // release sender; push lands on the edge of the first pop
        tx_status = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        @(negedge sysclk);
        wr_en = 1'b0;
        check_eq("pp level",    32'(level),    32'd16);
        check_eq("pp overflow", 32'(overflow), 32'd0);
        check_eq("pp tx_en",    32'(tx_en),    32'd1);

        for (int i = 1; i <= 16; i++) send_one(8'(i));
        send_one(8'h77);
        check_eq("burst drained empty", 32'(empty), 32'd1);
        check_eq("burst drained level", 32'(level), 32'd0);

        // ---------------- wrap: 40 bytes in groups of 5 ----------------
        repeat (5) @(negedge sysclk);
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < 5; j++) begin
                v = 8'(8'h80 + g * 5 + j);
                push(v);
            end
            for (int j = 0; j < 5; j++) begin
                v = 8'(8'h80 + g * 5 + j);
                send_one(v);
            end
        end
        check_eq("wrap empty", 32'(empty), 32'd1);

        // ---------------- reset mid-LAUNCH ----------------
        repeat (5) @(negedge sysclk);
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        check_eq("pre-rst tx_en", 32'(tx_en), 32'd1);
        check_eq("pre-rst level", 32'(level), 32'd3);
        tx_status = 1'b0;
        reset_    = 1'b0;
        #1;
        check_eq("async rst tx_en", 32'(tx_en), 32'd0);
        check_eq("async rst level", 32'(level), 32'd0);
        check_eq("async rst empty", 32'(empty), 32'd1);
        @(negedge sysclk);
        reset_ = 1'b1;
        repeat (3) @(negedge sysclk);
        push(8'h5A);
        repeat (10) @(negedge sysclk);
        check_eq("post-rst no pop tx_en", 32'(tx_en), 32'd0);
        check_eq("post-rst level",        32'(level), 32'd1);
        tx_status = 1'b1;
        send_one(8'h5A);
        repeat (5) @(negedge sysclk);

`ifdef UART_TXBUF_STATS_EN
        // ---------------- statistics ----------------
        clr_ovf = 1'b1;
        @(negedge sysclk);
        clr_ovf = 1'b0;
        check_eq("stat clr sent", 32'(sent_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h10 + i));
            send_one(8'(8'h10 + i));
        end
        repeat (5) @(negedge sysclk);
        check_eq("stat sent5", 32'(sent_cnt), 32'd5);
        tx_status = 1'b0;
        repeat (4) @(negedge sysclk);
        for (int i = 0; i < 18; i++) push(8'(8'h20 + i));
        check_eq("stat drop2",  32'(drop_cnt), 32'd2);
        check_eq("stat sent5b", 32'(sent_cnt), 32'd5);
        clr_ovf = 1'b1;
        @(negedge sysclk);
        clr_ovf = 1'b0;
        check_eq("stat clr sent0", 32'(sent_cnt), 32'd0);
        check_eq("stat clr drop0", 32'(drop_cnt), 32'd0);
        check_eq("stat clr ovf",   32'(overflow), 32'd0);
        tx_status = 1'b1;
        for (int i = 0; i < 16; i++) send_one(8'(8'h20 + i));
        repeat (5) @(negedge sysclk);
        check_eq("stat sent16", 32'(sent_cnt), 32'd16);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_buffer
`default_nettype wire

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO and launch sequencer sitting directly upstream of the UART sender.
- Accepts bytes from the CPU peripheral bus in the sysclk domain and holds them.
- Issues one byte at a time to the sender using its tx_en/tx_status handshake. The CPU can queue a burst of bytes instead of polling TX status per byte.

Parameters:
- DEPTH, 16: FIFO entries; power of 2, minimum 2.
- AW, $clog2(DEPTH): pointer width.
- SYNC_STAGES, 2: flops in the tx_status synchronizer; minimum 2.

Ports:
- sysclk  input  1  system clock; all state is on its rising edge.
- reset_  input  1  asynchronous, active-low reset.
- wr_en  input  1  push request; sampled on the sysclk edge.
- wr_data  input  8  byte to push.
- clr_ovf  input  1  clears the overflow flag.
- tx_status  input  1  sender idle flag: 1 = idle, 0 = busy. Asynchronous to sysclk (baud domain).
- tx_en  output  1  launch request to the sender.
- tx_data  output  8  byte presented to the sender; stable while a launch or transmission is in progress.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  AW+1  current entry count.
- overflow  output  1  sticky flag: a push was dropped.

Behaviour:
- Reset (reset_ low, takes effect immediately):
  - Pointers 0, level 0, empty 1, full 0, overflow 0.
  - tx_en 0, tx_data 8'h00, FSM in IDLE.
  - Synchronizer flops preset to 1 (idle).
- tx_status passes through SYNC_STAGES flops to give st_s. The FSM uses only st_s.
- Push:
  - Accepted when wr_en && (!full || pop this cycle). The byte is written at wr_ptr, which increments modulo DEPTH.
  - wr_en && full with no pop this cycle: byte dropped, pointers unchanged, overflow set.
- overflow is cleared by clr_ovf. If a drop and clr_ovf occur in the same cycle, set wins.
- Pop (internal): occurs when FSM is IDLE && !empty && st_s==1.
  - mem[rd_ptr] is loaded into tx_data, rd_ptr increments modulo DEPTH, tx_en is set to 1, FSM goes to LAUNCH.
- Level and flag updates:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - full and empty are derived from registered level.
  - No fall-through: a byte pushed into an empty FIFO is popped on the following edge at the earliest.
- FSM (3 states):
  - IDLE: tx_en 0. Pops when the condition above holds.
  - LAUNCH: tx_en held 1 until st_s==0 (sender has acknowledged), then tx_en goes to 0 and FSM goes to BUSY. tx_en is level-held because the sender latches it on a baud-domain edge.
  - BUSY: tx_en 0. When st_s==1, go to IDLE. The next pop can occur on the following edge.
- Latency: a push sampled at edge k into an empty FIFO with the sender idle gives tx_en=1 after edge k+1.
- Wrap-around: pointers are AW bits; level distinguishes full from empty.
- Reset mid-transmission: the buffer clears. The sender's frame in flight is not aborted by this block. After reset, the FSM will not pop until st_s reads 1.
- tx_data changes only on a pop.

Optional Feature:
- Macro: UART_TXBUF_STATS_EN.
- Defined:
  - Adds output sent_cnt[15:0], reset to 0, incremented on each LAUNCH-to-BUSY transition, wrapping at 16'hFFFF.
  - Adds output drop_cnt[7:0], incremented on each dropped push and saturating at 8'hFF.
  - Both counters are cleared by clr_ovf. If an increment and clr_ovf occur in the same cycle, the clear wins.
- Undefined: neither port nor any counter logic exists. Behaviour is otherwise identical.

Decomposition:
- Shared uart_pkg:
  - FSM state typedef: IDLE, LAUNCH, BUSY.
  - Address constant for the TX data register, 32'h40000018.
  - Default depth constant.
- One natural sub-module, uart_status_sync: a SYNC_STAGES-deep synchronizer with reset preset to 1. It is reusable for rx_status on the receive side.
- FIFO storage stays inline.

Test Plan:
- Single byte: push 8'hA5 with tx_status=1. Expect tx_en high from edge k+1 and tx_data=8'hA5. Drive tx_status=0: tx_en drops SYNC_STAGES+1 edges later. Drive tx_status=1: FSM returns to IDLE, empty=1.
- Burst:
  - Push 8'h01..8'h10 (16 bytes) back to back with the sender model busy. Expect full=1, level=16.
  - Push a 17th byte 8'hFF: overflow=1, level stays 16.
  - Release the sender: bytes emerge 8'h01..8'h10 in order, then empty=1.
- Simultaneous push and pop at full:
  - While level=16 and a pop fires, push 8'h77. Expect level stays 16, overflow unchanged, and 8'h77 is transmitted last.
  - clr_ovf together with a drop leaves overflow=1; a later clr_ovf alone clears it.
- Wrap: push and drain 40 bytes in groups of 5. Expect pointers wrap twice and the output sequence matches the input exactly.
- Reset mid-LAUNCH: assert reset_=0 while tx_en=1 and level=3. Expect tx_en=0, level=0, empty=1 immediately. With tx_status=0 held after release, no pop occurs until tx_status returns to 1.
- UART_TXBUF_STATS_EN build: send 5 bytes and drop 2. Expect sent_cnt=5, drop_cnt=2; clr_ovf zeroes both.
